// File: rtl/slow_tick_sampler.sv
// Brings a slow asynchronous clock into the clk domain as a one-cycle tick enable,
// samples a debounced serial bit on each tick, measures tick spacing and flags slow-clock loss.
module slow_tick_sampler #(
    parameter int DEBOUNCE = 16,
    parameter int TIMEOUT  = 250000000,
    parameter int CNT_W    = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_in,
    input  logic             din,
    output logic             tick,
    output logic             bit_valid,
    output logic             bit_out,
    output logic [CNT_W-1:0] period,
    output logic             lost
);

    localparam int               DW      = $clog2(DEBOUNCE);
    localparam logic [DW-1:0]    DC_LAST = DW'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             s_meta_q, s_meta_d;
    logic             s_sync_q, s_sync_d;
    logic             s_prev_q, s_prev_d;
    logic             d_meta_q, d_meta_d;
    logic             d_sync_q, d_sync_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             din_clean_q, din_clean_d;
    logic             tick_q, tick_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_out_q, bit_out_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             seen_q, seen_d;
    logic             lost_q, lost_d;
    logic             rise;
    logic             pcnt_sat;

    assign rise     = s_sync_q & ~s_prev_q;
    assign pcnt_sat = (pcnt_q == '1);

    always_comb begin
        s_meta_d    = slow_in;
        s_sync_d    = s_meta_q;
        s_prev_d    = s_sync_q;
        d_meta_d    = din;
        d_sync_d    = d_meta_q;
        dcnt_d      = dcnt_q;
        din_clean_d = din_clean_q;
        tick_d      = rise;
        bit_valid_d = rise;
        bit_out_d   = bit_out_q;
        pcnt_d      = pcnt_q;
        period_d    = period_q;
        seen_d      = seen_q;
        lost_d      = lost_q;

        if (d_sync_q == din_clean_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DC_LAST) begin
            din_clean_d = d_sync_q;
            dcnt_d      = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        // The tick edge restarts the period count and always wins over the timeout.
        if (rise) begin
            bit_out_d = din_clean_q;
            pcnt_d    = '0;
            seen_d    = 1'b1;
            lost_d    = 1'b0;
            if (seen_q) begin
                period_d = pcnt_sat ? pcnt_q : pcnt_q + CNT_W'(1);
            end
        end else begin
            if (!pcnt_sat) begin
                pcnt_d = pcnt_q + CNT_W'(1);
            end
            if (pcnt_q == TO_LAST) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta_q    <= 1'b0;
            s_sync_q    <= 1'b0;
            s_prev_q    <= 1'b0;
            d_meta_q    <= 1'b0;
            d_sync_q    <= 1'b0;
            dcnt_q      <= '0;
            din_clean_q <= 1'b0;
            tick_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            pcnt_q      <= '0;
            period_q    <= '0;
            seen_q      <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            s_meta_q    <= s_meta_d;
            s_sync_q    <= s_sync_d;
            s_prev_q    <= s_prev_d;
            d_meta_q    <= d_meta_d;
            d_sync_q    <= d_sync_d;
            dcnt_q      <= dcnt_d;
            din_clean_q <= din_clean_d;
            tick_q      <= tick_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            pcnt_q      <= pcnt_d;
            period_q    <= period_d;
            seen_q      <= seen_d;
            lost_q      <= lost_d;
        end
    end

    assign tick      = tick_q;
    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign period    = period_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_slow_tick_sampler.sv
// Directed bench for slow_tick_sampler: one instance for timing/debounce/loss/reset,
// a narrow-counter instance for period saturation and release-while-high behaviour.
module tb_slow_tick_sampler;

    logic        clk;
    logic        reset;
    logic        slow_in, din;
    logic        tick, bit_valid, bit_out, lost;
    logic [27:0] period;
    logic        slow_sat, din_sat;
    logic        tick_sat, bit_valid_sat, bit_out_sat, lost_sat;
    logic [5:0]  period_sat;

    int n_checks = 0;
    int n_fail   = 0;

    slow_tick_sampler #(.DEBOUNCE(4), .TIMEOUT(100), .CNT_W(28)) dut (
        .clk(clk), .reset(reset), .slow_in(slow_in), .din(din),
        .tick(tick), .bit_valid(bit_valid), .bit_out(bit_out),
        .period(period), .lost(lost)
    );

    slow_tick_sampler #(.DEBOUNCE(4), .TIMEOUT(60), .CNT_W(6)) dut_sat (
        .clk(clk), .reset(reset), .slow_in(slow_sat), .din(din_sat),
        .tick(tick_sat), .bit_valid(bit_valid_sat), .bit_out(bit_out_sat),
        .period(period_sat), .lost(lost_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One slow_in cycle: rise, check the tick 3 edges later, optional 2-cycle din glitch.
    task automatic wave(input int hi, input int lo, input int exp_per,
                        input logic exp_bit, input bit glitch);
        slow_in = 1'b1;
        step(2);
        chk_eq("tick_early", 32'(tick), 0);
        step(1);
        chk_eq("tick", 32'(tick), 1);
        chk_eq("bit_valid", 32'(bit_valid), 1);
        chk_eq("bit_out", 32'(bit_out), 32'(exp_bit));
        chk_eq("period", 32'(period), exp_per);
        chk_eq("lost", 32'(lost), 0);
        step(1);
        chk_eq("tick_fall", 32'(tick), 0);
        chk_eq("bit_valid_fall", 32'(bit_valid), 0);
        chk_eq("bit_out_hold", 32'(bit_out), 32'(exp_bit));
        if (glitch) begin
            din = 1'b0;
            step(2);
            din = 1'b1;
            step(hi - 6);
        end else begin
            step(hi - 4);
        end
        slow_in = 1'b0;
        step(lo);
    endtask

    initial begin
        reset    = 1'b1;
        slow_in  = 1'b0;
        din      = 1'b0;
        slow_sat = 1'b1;
        din_sat  = 1'b0;
        step(1);

        for (int i = 0; i < 3; i++) begin
            slow_in = i[0];
            din     = ~i[0];
            step(1);
            chk_eq("reset_outs", {tick, bit_valid, bit_out, lost, period}, 0);
            chk_eq("reset_sat_outs", 32'({tick_sat, bit_valid_sat, lost_sat, period_sat}), 0);
        end

        slow_in = 1'b0;
        din     = 1'b0;
        reset   = 1'b0;
        step(1);
        chk_eq("post_reset_outs", {tick, bit_valid, bit_out, lost, period}, 0);
        chk_eq("sat_tick_e1", 32'(tick_sat), 0);
        step(1);
        chk_eq("sat_tick_e2", 32'(tick_sat), 0);
        step(1);
        chk_eq("sat_tick_high_release", 32'(tick_sat), 1);
        chk_eq("sat_period_first", 32'(period_sat), 0);
        step(1);
        chk_eq("sat_tick_once", 32'(tick_sat), 0);
        chk_eq("no_tick_after_reset", 32'(tick), 0);

        din = 1'b1;
        step(10);

        wave(10, 10, 0, 1'b1, 1'b0);
        wave(10, 10, 20, 1'b1, 1'b0);
        wave(10, 10, 20, 1'b1, 1'b1);
        wave(10, 10, 20, 1'b1, 1'b0);

        // din_clean flips on the very edge that samples: bit_out takes the old value.
        din = 1'b0;
        step(3);
        wave(10, 10, 23, 1'b1, 1'b0);
        wave(10, 10, 20, 1'b0, 1'b0);

        slow_in = 1'b1;
        step(3);
        chk_eq("loss_ref_tick", 32'(tick), 1);
        chk_eq("loss_ref_period", 32'(period), 20);
        step(7);
        slow_in = 1'b0;
        step(92);
        chk_eq("lost_at_99", 32'(lost), 0);
        step(1);
        chk_eq("lost_at_100", 32'(lost), 1);
        step(50);
        chk_eq("lost_sticky", 32'(lost), 1);
        slow_in = 1'b1;
        step(2);
        chk_eq("lost_before_tick", 32'(lost), 1);
        chk_eq("recover_tick_early", 32'(tick), 0);
        step(1);
        chk_eq("recover_tick", 32'(tick), 1);
        chk_eq("recover_lost", 32'(lost), 0);
        chk_eq("recover_period", 32'(period), 153);
        step(7);
        slow_in = 1'b0;
        step(10);
        wave(10, 10, 20, 1'b0, 1'b0);

        reset = 1'b1;
        step(1);
        chk_eq("midreset_period", 32'(period), 0);
        chk_eq("midreset_outs", {tick, bit_valid, bit_out, lost, period}, 0);
        reset = 1'b0;
        wave(10, 10, 0, 1'b0, 1'b0);
        wave(10, 10, 20, 1'b0, 1'b0);

        step(100);
        slow_sat = 1'b0;
        step(3);
        chk_eq("sat_lost_idle", 32'(lost_sat), 1);
        slow_sat = 1'b1;
        step(2);
        chk_eq("sat_lost_pre", 32'(lost_sat), 1);
        step(1);
        chk_eq("sat_tick_a", 32'(tick_sat), 1);
        chk_eq("sat_lost_clear_a", 32'(lost_sat), 0);
        chk_eq("sat_period_a", 32'(period_sat), 63);
        step(59);
        chk_eq("sat_lost_59", 32'(lost_sat), 0);
        step(1);
        chk_eq("sat_lost_60", 32'(lost_sat), 1);
        slow_sat = 1'b0;
        step(17);
        slow_sat = 1'b1;
        step(2);
        chk_eq("sat_tick_b_early", 32'(tick_sat), 0);
        chk_eq("sat_lost_b_pre", 32'(lost_sat), 1);
        step(1);
        chk_eq("sat_tick_b", 32'(tick_sat), 1);
        chk_eq("sat_lost_clear_b", 32'(lost_sat), 0);
        chk_eq("sat_period_b", 32'(period_sat), 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
